fir_mac_seq: RTL and testbench
==============================

# fir_mac_seq

Time-multiplexed FIR filter core directly upstream of and wrapping the `shift_mul` shift-add multiplier. Accepts 4-bit signed samples over a valid/ready handshake and keeps a TAPS-deep delay line plus a writable 9-bit signed coefficient bank. Feeds one (sample, coefficient) pair per cycle into a single `shift_mul` and accumulates the 16-bit products. Emits one 16-bit filter output per accepted sample.

## Interface
- `TAPS`, 16: filter length; legal range 2..32.
- `ACC_W`, 16+$clog2(TAPS): accumulator width.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  sample present.
- `in`  in  4  signed input sample.
- `in_ready`  out  1  high only in IDLE.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  $clog2(TAPS)  tap index.
- `coef_data`  in  9  signed coefficient.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts result.
- `y`  out  16  signed filter output.

## Operation
- FSM states are IDLE, MAC and DONE; reset enters IDLE.
- Reset values: `in_ready`=1, `out_valid`=0, `y`=0. Delay line, coefficients, accumulator and tap counter `k` all reset to 0.
- IDLE, on `in_valid && in_ready`:
  - delay line shifts (x[i] <= x[i-1], x[0] <= `in`)
  - accumulator clears, `k` clears
  - next state is MAC.
- MAC, each cycle:
  - `shift_mul` gets `in`=x[k], `h`=h[k]
  - accumulator becomes acc + sign-extended product
  - `k` increments.
- MAC exit, at k==TAPS-1:
  - final sum is formed as acc + product
  - `y` is registered from the final sum on that edge
  - next state is DONE.
- DONE: `out_valid`=1 and `y` is held stable. On `out_ready`, go to IDLE and drop `out_valid`.
- Arithmetic: products are signed 16-bit, sign-extended to ACC_W. The accumulator never overflows for TAPS≤32.
- Output conversion from ACC_W to 16 bits follows Configuration.
- Coefficient writes:
  - applied on the edge only when the state is IDLE
  - silently dropped in MAC and DONE
  - when a write and a sample acceptance happen on the same IDLE edge, the write lands and the new coefficient is used for that sample.
- An out-of-range `coef_addr` (TAPS not a power of 2) is ignored.

## Timing
- Sample accepted on edge E. Accumulation runs on edges E+1..E+TAPS.
- `out_valid` rises after edge E+TAPS, giving a latency of TAPS cycles.
- Minimum sample period is TAPS+2 cycles: accept, TAPS MAC cycles, then a DONE cycle with `out_ready`=1.
- `in_ready` is low throughout MAC and DONE. An `in_valid` asserted in DONE together with `out_ready` is not taken; it is accepted on the following IDLE cycle.
- Backpressure: `y`/`out_valid` are held indefinitely while `out_ready`=0.
- Reset asserted mid-MAC or in DONE:
  - immediately returns to reset values
  - the partial sum is lost
  - the delay line is cleared.

## Configuration
- `FIR_SAT_EN` defined: the ACC_W sum is clamped to [-32768, 32767] when loaded into `y`.
- `FIR_SAT_EN` undefined: `y` is the low 16 bits of the sum, i.e. two's-complement wrap.

## Structure
- Package `fir_pkg` holds:
  - the FSM state enum (IDLE/MAC/DONE)
  - sample width 4, coefficient width 9, product width 16, output width 16
  - `Y_MAX`/`Y_MIN` saturation constants.
- One sub-module: the existing `shift_mul`, instantiated once, combinational, fed from the tap mux.
- Delay line, coefficient bank, counter and accumulator stay inline.

## Test plan
- Impulse response: write h[k]=k+1 for k=0..15, then send samples 1,0,0,...
  - required outputs: 1,2,3,...,16, then 0.
- Negative coefficients: all h=-256, eight samples of 3 after reset.
  - required outputs: -768, -1536, ..., -6144.
- Overflow: all h=-256, sixteen samples of -8.
  - 16th output is 32767 with `FIR_SAT_EN` and -32768 without it; the earlier 15 outputs are 2048·n.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE.
  - `y` stays stable, `in_ready`=0, and a pending `in_valid` is accepted only after the handshake completes.
- Coefficient write in MAC: write h[3]=100 during MAC.
  - no effect on the current output; a later IDLE write takes effect on the next sample.
- Reset mid-MAC: pulse `rst_n` low at MAC cycle 7.
  - `out_valid`=0, `y`=0, `in_ready`=1; the next impulse yields a coefficient-free output of 0 because the coefficients were reset.

Source files
------------

// File: rtl/fir_mac_seq_pkg.sv
// Shared types and widths for the fir_mac_seq FIR core.
package fir_pkg;

    localparam int unsigned SAMPLE_W = 4;
    localparam int unsigned COEF_W   = 9;
    localparam int unsigned PROD_W   = 16;
    localparam int unsigned Y_W      = 16;

    localparam logic signed [Y_W-1:0] Y_MAX = 16'sh7FFF;
    localparam logic signed [Y_W-1:0] Y_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } fir_state_e;

    // Clamp a sign-extended sum into the 16-bit output range.
    function automatic logic signed [Y_W-1:0] sat_y(input logic signed [31:0] v);
        if (v > 32'(Y_MAX)) begin
            return Y_MAX;
        end else if (v < 32'(Y_MIN)) begin
            return Y_MIN;
        end
        return Y_W'(v);
    endfunction

endpackage

// File: rtl/fir_mac_seq_if.sv
// Sample, coefficient and result handshake bundle for fir_mac_seq.
interface fir_mac_seq_if
    import fir_pkg::*;
#(
    parameter int unsigned TAPS = 16
);
    localparam int unsigned AW = $clog2(TAPS);

    logic                       in_valid;
    logic                       in_ready;
    logic signed [SAMPLE_W-1:0] in;
    logic                       coef_we;
    logic [AW-1:0]              coef_addr;
    logic signed [COEF_W-1:0]   coef_data;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [Y_W-1:0]      y;

    modport master (
        output in_valid, in, coef_we, coef_addr, coef_data, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, in, coef_we, coef_addr, coef_data, out_ready,
        output in_ready, out_valid, y
    );

endinterface

// File: rtl/fir_mac_seq_shift_mul.sv
// Combinational signed shift-add multiplier: 4-bit sample times 9-bit coefficient.
module shift_mul
    import fir_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] in,
    input  logic signed [COEF_W-1:0]   h,
    output logic signed [PROD_W-1:0]   p
);

    logic signed [PROD_W-1:0] h_ext;
    logic signed [PROD_W-1:0] sum;

    assign h_ext = PROD_W'(h);

    // The sample MSB carries negative weight, so its partial product is subtracted.
    always_comb begin
        sum = '0;
        for (int i = 0; i < int'(SAMPLE_W); i++) begin
            if (in[i]) begin
                if (i == int'(SAMPLE_W) - 1) begin
                    sum = sum - (h_ext <<< i);
                end else begin
                    sum = sum + (h_ext <<< i);
                end
            end
        end
    end

    assign p = sum;

endmodule

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR core: one tap per cycle through a single shift_mul.
// Build option: FIR_SAT_EN clamps the output instead of wrapping it.
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int unsigned TAPS = 16
)(
    input  logic          clk,
    input  logic          rst_n,
    fir_mac_seq_if.slave  bus
);

    localparam int unsigned AW    = $clog2(TAPS);
    localparam int unsigned ACC_W = PROD_W + $clog2(TAPS);
    localparam logic [AW:0] TAPS_L = (AW+1)'(TAPS);
    localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

    fir_state_e                 state_q, state_d;
    logic [AW-1:0]              k_q, k_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [SAMPLE_W-1:0] x_q [TAPS];
    logic signed [SAMPLE_W-1:0] x_d [TAPS];
    logic signed [COEF_W-1:0]   h_q [TAPS];
    logic signed [COEF_W-1:0]   h_d [TAPS];
    logic signed [Y_W-1:0]      y_q, y_d;
    logic                       out_valid_q, out_valid_d;
    logic                       in_ready_q, in_ready_d;

    logic signed [PROD_W-1:0]   prod_c;
    logic signed [ACC_W-1:0]    sum_c;
    logic signed [Y_W-1:0]      y_conv_c;
    logic                       addr_ok_c;

    shift_mul u_mul (
        .in (x_q[k_q]),
        .h  (h_q[k_q]),
        .p  (prod_c)
    );

    assign sum_c     = acc_q + ACC_W'(prod_c);
    assign addr_ok_c = {1'b0, bus.coef_addr} < TAPS_L;

`ifdef FIR_SAT_EN
    assign y_conv_c = sat_y(32'(sum_c));
`else
    assign y_conv_c = sum_c[Y_W-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        x_d         = x_q;
        h_d         = h_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        // Coefficient bank is only writable while idle; lands before a same-edge sample's MAC.
        if (state_q == ST_IDLE && bus.coef_we && addr_ok_c) begin
            h_d[bus.coef_addr] = bus.coef_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    for (int i = int'(TAPS) - 1; i > 0; i--) begin
                        x_d[i] = x_q[i-1];
                    end
                    x_d[0]     = bus.in;
                    acc_d      = '0;
                    k_d        = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = sum_c;
                k_d   = k_q + AW'(1);
                if (k_q == K_LAST) begin
                    y_d         = y_conv_c;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            for (int i = 0; i < int'(TAPS); i++) begin
                x_q[i] <= '0;
                h_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            x_q         <= x_d;
            h_q         <= h_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq: directed tables, corner sequences and a random run.
module tb_fir_mac_seq;
    import fir_pkg::*;

    localparam int unsigned TAPS = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_mac_seq_if #(.TAPS(TAPS)) bus ();

    fir_mac_seq #(.TAPS(TAPS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int s;
        int exp_y;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int mdl_x [TAPS];
    int mdl_h [TAPS];

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Direct convolution of the modelled delay line and coefficients.
    function automatic int model_y();
        int acc;
        logic signed [15:0] w;
        acc = 0;
        for (int i = 0; i < int'(TAPS); i++) acc += mdl_h[i] * mdl_x[i];
`ifdef FIR_SAT_EN
        if (acc > 32767) return 32767;
        if (acc < -32768) return -32768;
        return acc;
`else
        w = 16'(acc);
        return int'(w);
`endif
    endfunction

    task automatic model_accept(input int s);
        for (int i = int'(TAPS) - 1; i > 0; i--) mdl_x[i] = mdl_x[i-1];
        mdl_x[0] = s;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0; bus.in = '0; bus.coef_we = 1'b0;
        bus.coef_addr = '0; bus.coef_data = '0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < int'(TAPS); i++) begin mdl_x[i] = 0; mdl_h[i] = 0; end
        @(negedge clk);
    endtask

    task automatic write_coef(input int a, input int d);
        bus.coef_we = 1'b1; bus.coef_addr = 4'(a); bus.coef_data = 9'(d);
        @(negedge clk);
        bus.coef_we = 1'b0;
        mdl_h[a] = d;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < int'(TAPS) + 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic send_sample(input int s, input bit we, input int a, input int d,
                               input int hold, output int yv, output int lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
        check("accept_ready", int'(bus.in_ready), 1);
        bus.in_valid = 1'b1; bus.in = 4'(s);
        if (we) begin bus.coef_we = 1'b1; bus.coef_addr = 4'(a); bus.coef_data = 9'(d); end
        @(posedge clk);
        if (we) mdl_h[a] = d;
        model_accept(s);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.coef_we = 1'b0;
        wait_out(lat);
        yv = int'(bus.y);
        repeat (hold) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        int yv, lat, y0, s, hold;
        bit we;

        // Reset state
        do_reset();
        check("reset_in_ready", int'(bus.in_ready), 1);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_y", int'(bus.y), 0);

        // Impulse response with h[k] = k+1
        for (int k = 0; k < int'(TAPS); k++) write_coef(k, k + 1);
        vecs.delete();
        v.s = 1; v.exp_y = 1; vecs.push_back(v);
        for (int k = 1; k < int'(TAPS); k++) begin v.s = 0; v.exp_y = k + 1; vecs.push_back(v); end
        v.s = 0; v.exp_y = 0; vecs.push_back(v);
        for (int i = 0; i < vecs.size(); i++) begin
            send_sample(vecs[i].s, 1'b0, 0, 0, 0, yv, lat);
            check($sformatf("impulse_y[%0d]", i), yv, vecs[i].exp_y);
            if (i == 0) check("latency", lat, int'(TAPS));
        end

        // Negative coefficients
        do_reset();
        for (int k = 0; k < int'(TAPS); k++) write_coef(k, -256);
        vecs.delete();
        for (int n = 1; n <= 8; n++) begin v.s = 3; v.exp_y = -768 * n; vecs.push_back(v); end
        for (int i = 0; i < vecs.size(); i++) begin
            send_sample(vecs[i].s, 1'b0, 0, 0, 0, yv, lat);
            check($sformatf("neg_y[%0d]", i), yv, vecs[i].exp_y);
        end

        // Output range boundary at the 16th sample
        do_reset();
        for (int k = 0; k < int'(TAPS); k++) write_coef(k, -256);
        vecs.delete();
        for (int n = 1; n <= 15; n++) begin v.s = -8; v.exp_y = 2048 * n; vecs.push_back(v); end
`ifdef FIR_SAT_EN
        v.s = -8; v.exp_y = 32767; vecs.push_back(v);
`else
        v.s = -8; v.exp_y = -32768; vecs.push_back(v);
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            send_sample(vecs[i].s, 1'b0, 0, 0, 0, yv, lat);
            check($sformatf("ovf_y[%0d]", i), yv, vecs[i].exp_y);
        end

        // Coefficient write during MAC is dropped; an idle write is used next sample
        do_reset();
        for (int k = 0; k < int'(TAPS); k++) write_coef(k, k + 1);
        repeat (4) send_sample(5, 1'b0, 0, 0, 0, yv, lat);
        bus.in_valid = 1'b1; bus.in = 4'(1);
        @(posedge clk);
        model_accept(1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.coef_we = 1'b1; bus.coef_addr = 4'(3); bus.coef_data = 9'(100);
        @(negedge clk);
        bus.coef_we = 1'b0;
        wait_out(lat);
        check("mac_write_dropped", int'(bus.y), 71);
        check("mac_write_model", int'(bus.y), model_y());
        bus.out_ready = 1'b1; @(negedge clk); bus.out_ready = 1'b0;
        write_coef(3, 100);
        send_sample(0, 1'b0, 0, 0, 0, yv, lat);
        check("idle_write_used", yv, 572);

        // Backpressure with a pending sample
        send_sample(7, 1'b0, 0, 0, 0, yv, lat);
        check("bp_pre_y", yv, model_y());
        bus.in_valid = 1'b1; bus.in = 4'(2);
        @(posedge clk);
        model_accept(2);
        @(negedge clk);
        bus.in = 4'(-3);
        wait_out(lat);
        y0 = int'(bus.y);
        check("bp_y", y0, model_y());
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_y_stable", int'(bus.y), y0);
            check("bp_in_ready_low", int'(bus.in_ready), 0);
            check("bp_out_valid_held", int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_release_in_ready", int'(bus.in_ready), 1);
        check("bp_release_out_valid", int'(bus.out_valid), 0);
        @(posedge clk);
        model_accept(-3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_pending_taken", int'(bus.in_ready), 0);
        wait_out(lat);
        check("bp_pending_latency", lat, int'(TAPS));
        check("bp_pending_y", int'(bus.y), model_y());
        bus.out_ready = 1'b1; @(negedge clk); bus.out_ready = 1'b0;

        // Reset in the middle of MAC
        send_sample(4, 1'b0, 0, 0, 0, yv, lat);
        check("pre_rst_y", yv, model_y());
        bus.in_valid = 1'b1; bus.in = 4'(6);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_y", int'(bus.y), 0);
        check("midrst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < int'(TAPS); i++) begin mdl_x[i] = 0; mdl_h[i] = 0; end
        @(negedge clk);
        send_sample(1, 1'b0, 0, 0, 0, yv, lat);
        check("post_rst_impulse", yv, 0);

        // Random samples and coefficients, with same-edge writes and random backpressure
        do_reset();
        for (int k = 0; k < int'(TAPS); k++) write_coef(k, int'($urandom_range(0, 511)) - 256);
        for (int n = 0; n < 60; n++) begin
            s    = int'($urandom_range(0, 15)) - 8;
            we   = ($urandom_range(0, 3) == 0);
            hold = int'($urandom_range(0, 3));
            send_sample(s, we, int'($urandom_range(0, TAPS - 1)),
                        int'($urandom_range(0, 511)) - 256, hold, yv, lat);
            check($sformatf("rand_y[%0d]", n), yv, model_y());
            check($sformatf("rand_lat[%0d]", n), lat, int'(TAPS));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
